serial_slice_adder_ctrl: RTL and testbench

//  Sequencer that performs a WIDTH-bit addition by driving an external combinational
//  2-bit adder slice (ports a0,b0,a1,b1,c0 -> s0,s1,c2) two bits per clock.

---
 rtl/serial_slice_adder_ctrl.sv | 99 +++++++++
 tb/tb_serial_slice_adder_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_slice_adder_ctrl.sv
// Two-bits-per-clock adder sequencer: feeds an external 2-bit adder slice LSB pair first,
// keeps the inter-slice carry in a flop and assembles the WIDTH-bit result.
module serial_slice_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             sl_a0,
  output logic             sl_b0,
  output logic             sl_a1,
  output logic             sl_b1,
  output logic             sl_c0,
  input  logic             sl_s0,
  input  logic             sl_s1,
  input  logic             sl_c2
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;

  // New slice sum enters at the top; after HALF shifts the first pair sits at bit 0.
  generate
    if (WIDTH == 2) begin : g_narrow
      assign acc_nxt = {sl_s1, sl_s0};
    end else begin : g_wide
      assign acc_nxt = {sl_s1, sl_s0, acc[WIDTH-1:2]};
    end
  endgenerate

  assign last = (cnt == CW'(HALF - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= cin;
          cnt   <= '0;
          acc   <= '0;
          state <= RUN;
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= sl_c2;
          a_sh  <= a_sh >> 2;
          b_sh  <= b_sh >> 2;
          if (last) begin
            sum   <= acc_nxt;
            cout  <= sl_c2;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Slice inputs are gated so it only ever sees live operands during RUN.
  assign sl_a0 = busy & a_sh[0];
  assign sl_b0 = busy & b_sh[0];
  assign sl_a1 = busy & a_sh[1];
  assign sl_b1 = busy & b_sh[1];
  assign sl_c0 = busy & carry;

endmodule

// File: tb/tb_serial_slice_adder_ctrl.sv
// Directed bench: WIDTH=8 and WIDTH=2 sequencers, each driving a NOR-gate 2-bit adder slice.
module tb_serial_slice_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic nor2(input logic x, input logic y);
    return ~(x | y);
  endfunction

  // Full adder built only from 2-input NORs; returns {carry, sum}.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic c);
    logic n1, n2, n3, xnr, xr, m1, m2, m3, sx, ci, cand1, cand2;
    n1 = nor2(x, y);  n2 = nor2(x, n1); n3 = nor2(y, n1);
    xnr = nor2(n2, n3); xr = nor2(xnr, xnr);
    m1 = nor2(xr, c); m2 = nor2(xr, m1); m3 = nor2(c, m1);
    sx = nor2(nor2(m2, m3), nor2(m2, m3));
    ci = nor2(nor2(c, c), nor2(xr, xr));
    cand1 = nor2(nor2(x, x), nor2(y, y));
    cand2 = nor2(nor2(ci, cand1), nor2(ci, cand1));
    return {cand2, sx};
  endfunction

  // WIDTH=8 instance
  logic       start, cin, busy, done, cout;
  logic [7:0] a, b, sum;
  logic       sl_a0, sl_b0, sl_a1, sl_b1, sl_c0, sl_s0, sl_s1, sl_c2, sl_c1;

  assign {sl_c1, sl_s0} = fa(sl_a0, sl_b0, sl_c0);
  assign {sl_c2, sl_s1} = fa(sl_a1, sl_b1, sl_c1);

  serial_slice_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .sl_a0(sl_a0), .sl_b0(sl_b0), .sl_a1(sl_a1), .sl_b1(sl_b1), .sl_c0(sl_c0),
    .sl_s0(sl_s0), .sl_s1(sl_s1), .sl_c2(sl_c2)
  );

  // WIDTH=2 instance
  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;
  logic       t_a0, t_b0, t_a1, t_b1, t_c0, t_s0, t_s1, t_c2, t_c1;

  assign {t_c1, t_s0} = fa(t_a0, t_b0, t_c0);
  assign {t_c2, t_s1} = fa(t_a1, t_b1, t_c1);

  serial_slice_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
    .sl_a0(t_a0), .sl_b0(t_b0), .sl_a1(t_a1), .sl_b1(t_b1), .sl_c0(t_c0),
    .sl_s0(t_s0), .sl_s1(t_s1), .sl_c2(t_c2)
  );

  logic [7:0] last_sum;
  logic       last_cout;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full WIDTH=8 operation started from IDLE; checks RUN, DONE and the return to IDLE.
  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                        input logic [7:0] es, input logic ec, input bit ripple);
    a = oa; b = ob; cin = oc; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("run_busy", busy, 1'b1);
      chk("run_done", done, 1'b0);
      chk("run_sum_held", {cout, sum}, {last_cout, last_sum});
      if (k == 1)
        chk("first_pair", {sl_a1, sl_a0, sl_b1, sl_b0, sl_c0}, {oa[1], oa[0], ob[1], ob[0], oc});
      if (ripple && k >= 2)
        chk("ripple_c0", sl_c0, 1'b1);
      step();
    end
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    chk("done_sl_zero", {sl_a0, sl_b0, sl_a1, sl_b1, sl_c0}, 5'b0);
    step();
    chk("done_clear", done, 1'b0);
    chk("idle_sum_hold", {cout, sum}, {ec, es});
    last_sum = es; last_cout = ec;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    last_sum = '0; last_cout = 1'b0;
    step(); step();
    chk("rst_state", {busy, done, cout, sum}, 11'b0);
    chk("rst_sl", {sl_a0, sl_b0, sl_a1, sl_b1, sl_c0}, 5'b0);
    rst = 1'b0;
    step();

    run_op(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
    run_op(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0);

    // start held high through RUN/DONE with changing operands
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    step();
    a = 8'hFF; b = 8'hFF;
    repeat (4) begin
      chk("hold_busy", busy, 1'b1);
      step();
    end
    chk("hold_done", done, 1'b1);
    chk("hold_sum", {cout, sum}, 9'h046);
    step();
    chk("hold_idle", {busy, done}, 2'b00);
    step();
    chk("hold_restart", busy, 1'b1);
    start = 1'b0;
    repeat (3) step();
    chk("hold_restart_run", busy, 1'b1);
    step();
    chk("hold2_done", done, 1'b1);
    chk("hold2_sum", {cout, sum}, 9'h1FE);
    step();
    last_sum = 8'hFE; last_cout = 1'b1;

    // reset in the second RUN cycle aborts the operation
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("abort_pre_busy", busy, 1'b1);
    rst = 1'b1;
    step();
    chk("abort_state", {busy, done, cout, sum}, 11'b0);
    chk("abort_sl", {sl_a0, sl_b0, sl_a1, sl_b1, sl_c0}, 5'b0);
    rst = 1'b0;
    last_sum = '0; last_cout = 1'b0;
    repeat (5) begin
      step();
      chk("abort_no_done", {busy, done}, 2'b00);
    end
    run_op(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);

    // exhaustive WIDTH=2
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          a2 = 2'(ia); b2 = 2'(ib); cin2 = 1'(ic); start2 = 1'b1;
          step();
          start2 = 1'b0;
          chk("w2_busy", {busy2, done2}, 2'b10);
          step();
          chk("w2_done", {busy2, done2}, 2'b01);
          chk("w2_result", {cout2, sum2}, 32'(ia + ib + ic));
          step();
        end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
